multichannel_adder: RTL

Parametrised channel-summation stage placed between the per-channel convolution output memories and the accelerator data-out path. On a start request it sequentially reads every output-feature location from up to NUM_CHANNELS channel memories and sums the selected channels as signed values. It adds a per-filter bias and applies optional ReLU and saturation. Each result is presented with a valid strobe, followed by the usual finished/finished-ok handshake.

---
 rtl/multichannel_adder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/multichannel_adder.sv
// Channel-summation stage: streams every output-feature location from the channel
// memories, sums the selected channels, adds bias, then applies optional ReLU and saturation.
module multichannel_adder #(
    parameter int unsigned NUM_CHANNELS         = 4,
    parameter int unsigned MEM_OUT_DATA_WIDTH   = 16,
    parameter int unsigned BITWIDTH_MAX_IF_SIZE = 22,
    parameter int unsigned BITWIDTH_IF_CHANNELS = 4,
    parameter int unsigned BITWIDTH_DATA_OUT    = 32,
    parameter int unsigned BITWIDTH_SAT         = 16
) (
    input  logic                                       MCADDER_Clk,
    input  logic                                       MCADDER_Reset,
    input  logic                                       MCADDER_Start_Routine,
    input  logic                                       MCADDER_Routine_Finished_Already_Ok,
    input  logic [BITWIDTH_IF_CHANNELS-1:0]            MCADDER_If_Channels,
    input  logic [BITWIDTH_MAX_IF_SIZE-1:0]            MCADDER_Of_Size,
    input  logic [BITWIDTH_DATA_OUT-1:0]               MCADDER_Bias,
    input  logic                                       MCADDER_Relu_En,
    input  logic                                       MCADDER_Sat_En,
    input  logic [NUM_CHANNELS*MEM_OUT_DATA_WIDTH-1:0] MCADDER_Mem_Data,
    output logic                                       MCADDER_Mems_Re,
    output logic [BITWIDTH_MAX_IF_SIZE-1:0]            MCADDER_Mems_Addr,
    output logic [BITWIDTH_DATA_OUT-1:0]               MCADDER_Out,
    output logic                                       MCADDER_Out_Valid,
    output logic                                       MCADDER_Routine_Finished_Already,
    output logic                                       MCADDER_Cfg_Error
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StDrain1,
        StDrain2,
        StDrain3,
        StDone
    } state_e;

    localparam logic signed [BITWIDTH_DATA_OUT-1:0] SatMax =
        BITWIDTH_DATA_OUT'((64'sd1 <<< (BITWIDTH_SAT - 1)) - 64'sd1);
    localparam logic signed [BITWIDTH_DATA_OUT-1:0] SatMin = ~SatMax;

    state_e                          state_q, state_d;
    logic [BITWIDTH_MAX_IF_SIZE-1:0] counter_q, counter_d;
    logic [BITWIDTH_MAX_IF_SIZE-1:0] of_size_q, of_size_d;
    logic [NUM_CHANNELS-1:0]         chan_mask_q, chan_mask_d;
    logic [BITWIDTH_DATA_OUT-1:0]    bias_q, bias_d;
    logic                            relu_q, relu_d;
    logic                            sat_q, sat_d;
    logic                            err_q, err_d;
    logic                            rd_valid_q;
    logic [BITWIDTH_DATA_OUT-1:0]    out_q;
    logic                            out_valid_q;
    logic                            chans_ok;

    logic signed [BITWIDTH_DATA_OUT-1:0] sum;
    logic signed [BITWIDTH_DATA_OUT-1:0] result;

    assign chans_ok = (MCADDER_If_Channels != '0) &&
                      (int'(MCADDER_If_Channels) <= int'(NUM_CHANNELS));

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        of_size_d   = of_size_q;
        chan_mask_d = chan_mask_q;
        bias_d      = bias_q;
        relu_d      = relu_q;
        sat_d       = sat_q;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (MCADDER_Start_Routine) begin
                    of_size_d = MCADDER_Of_Size;
                    bias_d    = MCADDER_Bias;
                    relu_d    = MCADDER_Relu_En;
                    sat_d     = MCADDER_Sat_En;
                    counter_d = '0;
                    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                        chan_mask_d[c] = c < int'(MCADDER_If_Channels);
                    end
                    if (chans_ok) begin
                        state_d = StRead;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StRead: begin
                if (counter_q == of_size_q) begin
                    state_d   = StDrain1;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + BITWIDTH_MAX_IF_SIZE'(1);
                end
            end
            StDrain1: state_d = StDrain2;
            StDrain2: state_d = StDrain3;
            // Extra drain cycle: finished rises two cycles after the last valid result.
            StDrain3: state_d = StDone;
            StDone: begin
                if (MCADDER_Routine_Finished_Already_Ok) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge MCADDER_Clk or posedge MCADDER_Reset) begin
        if (MCADDER_Reset) begin
            state_q     <= StIdle;
            counter_q   <= '0;
            of_size_q   <= '0;
            chan_mask_q <= '0;
            bias_q      <= '0;
            relu_q      <= 1'b0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            of_size_q   <= of_size_d;
            chan_mask_q <= chan_mask_d;
            bias_q      <= bias_d;
            relu_q      <= relu_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
        end
    end

    // Sum of selected channels plus bias, then ReLU, then saturation.
    always_comb begin
        sum = bias_q;
        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
            if (chan_mask_q[c]) begin
                sum = sum + BITWIDTH_DATA_OUT'(
                    $signed(MCADDER_Mem_Data[c*MEM_OUT_DATA_WIDTH +: MEM_OUT_DATA_WIDTH]));
            end
        end
        result = sum;
        if (relu_q && result[BITWIDTH_DATA_OUT-1]) begin
            result = '0;
        end
        if (sat_q) begin
            if (result > SatMax) begin
                result = SatMax;
            end else if (result < SatMin) begin
                result = SatMin;
            end
        end
    end

    // Memory data for a read issued in cycle t is valid in t+1 and registered at its end.
    always_ff @(posedge MCADDER_Clk or posedge MCADDER_Reset) begin
        if (MCADDER_Reset) begin
            rd_valid_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rd_valid_q  <= (state_q == StRead);
            out_valid_q <= rd_valid_q;
            out_q       <= rd_valid_q ? result : '0;
        end
    end

    assign MCADDER_Mems_Re                  = (state_q == StRead);
    assign MCADDER_Mems_Addr                = counter_q;
    assign MCADDER_Out                      = out_q;
    assign MCADDER_Out_Valid                = out_valid_q;
    assign MCADDER_Routine_Finished_Already = (state_q == StDone);
    assign MCADDER_Cfg_Error                = err_q;

endmodule
